// File: rtl/iterative_shifter_if.sv
// rtl/iterative_shifter_if.sv - request/result bundle for the iterative shifter
interface iterative_shifter_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) ();
  logic             start;
  logic [1:0]       mode;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] operand;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;

  modport master (
    output start, mode, amount, operand,
    input  busy, done, result, carry_out
  );

  modport slave (
    input  start, mode, amount, operand,
    output busy, done, result, carry_out
  );
endinterface

// File: rtl/iterative_shifter.sv
// rtl/iterative_shifter.sv - one-bit-per-cycle shifter (LSL/LSR/ASR, ROL when SHIFTER_ROTATE_EN is defined)
module iterative_shifter #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic                CLK,
  input  logic                Reset,
  iterative_shifter_if.slave  bus
);

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic [1:0]       mode_q;
  logic [AMT_W-1:0] count_q;

  logic [WIDTH-1:0] result_d;
  logic             carry_d;
  logic [AMT_W-1:0] load_count_d;

  // Single 1-bit step of the latched mode applied to the current result
  always_comb begin
    result_d = result_q;
    carry_d  = carry_q;
    case (mode_q)
      MODE_LSL: begin
        result_d = {result_q[WIDTH-2:0], 1'b0};
        carry_d  = result_q[WIDTH-1];
      end
      MODE_LSR: begin
        result_d = {1'b0, result_q[WIDTH-1:1]};
        carry_d  = result_q[0];
      end
      MODE_ASR: begin
        result_d = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
        carry_d  = result_q[0];
      end
`ifdef SHIFTER_ROTATE_EN
      MODE_ROL: begin
        result_d = {result_q[WIDTH-2:0], result_q[WIDTH-1]};
        carry_d  = result_q[WIDTH-1];
      end
`endif
      default: begin
        result_d = result_q;
        carry_d  = carry_q;
      end
    endcase
  end

  // Step count loaded on accept; without rotate support mode 11 completes with no steps
  always_comb begin
    load_count_d = bus.amount;
`ifndef SHIFTER_ROTATE_EN
    if (bus.mode == MODE_ROL) begin
      load_count_d = '0;
    end
`endif
  end

  // Control FSM with registered busy/done and the shifting datapath
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mode_q   <= MODE_LSL;
      count_q  <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q  <= SHIFT;
            result_q <= bus.operand;
            carry_q  <= 1'b0;
            mode_q   <= bus.mode;
            count_q  <= load_count_d;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        SHIFT: begin
          if (count_q != '0) begin
            result_q <= result_d;
            carry_q  <= carry_d;
            count_q  <= count_q - 1'b1;
          end else begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_q;

endmodule
